matrix_operand_loader: RTL
==========================

Name: matrix_operand_loader

Overview:
- Upstream stage of the matrix ALU. Accepts a serial stream of matrix elements over a valid/ready handshake and packs the A elements, then the B elements, into the flattened operand buses.
- Captures the op code for the frame, then presents A, B and op to the ALU as one stable, held operand set until the consumer accepts it.
- Malformed frames are detected, flagged and discarded.

Parameters:
- word_size, 8, bits per matrix element
- Amatrixrownum, 2, rows of A
- Amatrixcolnum, 2, columns of A
- Bmatrixrownum, 2, rows of B
- Bmatrixcolnum, 2, columns of B

Ports:
- clk  input  1  clock, rising edge
- resetn  input  1  reset, asynchronous, active-low
- in_data  input  word_size  element being streamed
- in_valid  input  1  in_data/in_op/in_last are valid
- in_ready  output  1  loader can accept an element this cycle
- in_last  input  1  marks the final element (last B element) of a frame
- in_op  input  2  op code; sampled with the first A element of a frame
- A  output  Amatrixrownum*Amatrixcolnum*word_size  packed matrix A
- B  output  Bmatrixrownum*Bmatrixcolnum*word_size  packed matrix B
- op  output  2  op code of the held frame
- out_valid  output  1  A/B/op hold a complete frame
- out_ready  input  1  consumer accepts the held frame
- frame_err  output  1  one-cycle pulse: malformed frame discarded

Behaviour:
- Derived counts: NA = Amatrixrownum*Amatrixcolnum, NB = Bmatrixrownum*Bmatrixcolnum.
- Packing: row-major. Element (r,c) of A sits at A[(r*Amatrixcolnum+c)*word_size +: word_size]; element 0 is in the LSBs. B is packed the same way.
- Stream order: NA A elements, then NB B elements, each row-major.
- Transfer rule: an element transfers when in_valid && in_ready at a rising edge. A transfer with in_ready=0 never happens.
- State machine states: LOAD_A, LOAD_B, HOLD. Element counter idx ranges 0..max(NA,NB)-1.
- LOAD_A:
  - in_ready=1.
  - On each transfer, write the element into A slot idx.
  - If idx==0, also latch in_op into op.
  - If idx==NA-1, go to LOAD_B with idx=0; otherwise idx++.
- LOAD_B:
  - in_ready=1.
  - On each transfer, write the element into B slot idx.
  - If idx==NB-1 and in_last=1, go to HOLD.
  - Otherwise idx++.
- HOLD:
  - in_ready=0, out_valid=1.
  - A, B and op are stable.
  - On out_ready=1, go to LOAD_A with idx=0.
  - A new frame can be accepted no earlier than the cycle after the handoff (one bubble cycle).
- Framing errors: a discarded frame returns to LOAD_A with idx=0, and frame_err pulses high for one cycle the cycle after the offending transfer.
  - in_last=1 on any transfer other than the final B element: discard.
  - in_last=0 on the final B element: discard.
- Discard side effects: A, B and op registers keep partially written contents; they are meaningless while out_valid=0.
- out_valid is a registered output, asserted exactly in HOLD.
- Latency: out_valid rises on the clock edge that transfers the final B element.
- Consumer timing: the ALU registers its result on the edge where out_valid && out_ready. The output is valid one cycle after handoff.
- Reset values, on asynchronous reset at any time including mid-frame or in HOLD:
  - state=LOAD_A, idx=0
  - A=0, B=0, op=2'b00
  - out_valid=0, frame_err=0
  - in_ready=1 once reset is released.
- out_ready while out_valid=0: ignored.
- in_valid while in HOLD: ignored; no data is consumed.
- Data and op widths are passed through unchanged; no arithmetic on data.

Decomposition:
- Shared package holds:
  - state encoding constants: LOAD_A=2'd0, LOAD_B=2'd1, HOLD=2'd2
  - op code constants: OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_KRO=2'b11
  - helper function for element slot offset (index*word_size)
- One natural sub-module: matrix_pack_reg, a parameterised register file of N word_size slots. It has write-enable and index inputs and a flattened output, and is instantiated once for A and once for B.
- The FSM and counters stay in the top module.

Test Plan:
- Reset, then stream 1,2,3,4 (A) and 5,6,7,8 (B) with in_op=2'b00 on the first element and in_last on 8 -> out_valid=1 after the 8th transfer edge; A=0x04030201, B=0x08070605, op=00; in_ready=0.
- Same frame with out_ready held low for 5 cycles, then pulsed -> A/B/op stable throughout; out_valid drops the next edge; in_ready=1; a second frame with op=2'b11 loads and holds op=11.
- in_last asserted on the 3rd element -> frame_err single-cycle pulse, out_valid stays 0; a following correct 8-element frame completes normally.
- Final element (8) sent with in_last=0 -> frame_err pulse, state returns to LOAD_A, out_valid=0.
- Random in_valid gaps (e.g. valid every 3rd cycle) on the same frame -> identical A/B/op as the back-to-back case; no element dropped or duplicated.
- Assert resetn low after 5 elements, and separately while in HOLD -> A=B=0, op=00, out_valid=0 immediately (asynchronous); the next full frame loads correctly.

Source files
------------

// File: rtl/matrix_operand_loader_pkg.sv
// Shared definitions for the matrix ALU operand loader: FSM states, op codes
// and the packed-slot offset helper.
package matrix_operand_loader_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_KRO = 2'b11;

  // Bit offset of element slot 'index' inside a flattened matrix bus.
  function automatic int slot_offset(input int index, input int word_size);
    return index * word_size;
  endfunction

endpackage

// File: rtl/matrix_pack_reg.sv
// Register file of depth word_size-bit slots, written one slot at a time and
// presented as a single flattened bus with slot 0 in the LSBs.
module matrix_pack_reg
  import matrix_operand_loader_pkg::*;
#(
  parameter int word_size = 8,
  parameter int depth     = 4,
  parameter int idx_width = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         wr_en,
  input  logic [idx_width-1:0]         wr_idx,
  input  logic [word_size-1:0]         wr_data,
  output logic [depth*word_size-1:0]   data
);

  for (genvar i = 0; i < depth; i++) begin : g_slot
    logic [word_size-1:0] slot_q;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        slot_q <= '0;
      end else if (wr_en && (wr_idx == idx_width'(i))) begin
        slot_q <= wr_data;
      end
    end

    assign data[slot_offset(i, word_size) +: word_size] = slot_q;
  end

endmodule

// File: rtl/matrix_operand_loader.sv
// Collects a serial stream of A then B elements plus an op code into one held
// operand set for the matrix ALU; malformed frames are flagged and dropped.
module matrix_operand_loader
  import matrix_operand_loader_pkg::*;
#(
  parameter int word_size     = 8,
  parameter int Amatrixrownum = 2,
  parameter int Amatrixcolnum = 2,
  parameter int Bmatrixrownum = 2,
  parameter int Bmatrixcolnum = 2
) (
  input  logic                                             clk,
  input  logic                                             resetn,
  input  logic [word_size-1:0]                             in_data,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic                                             in_last,
  input  logic [1:0]                                       in_op,
  output logic [Amatrixrownum*Amatrixcolnum*word_size-1:0] A,
  output logic [Bmatrixrownum*Bmatrixcolnum*word_size-1:0] B,
  output logic [1:0]                                       op,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic                                             frame_err
);

  localparam int NA        = Amatrixrownum * Amatrixcolnum;
  localparam int NB        = Bmatrixrownum * Bmatrixcolnum;
  localparam int MAX_N     = (NA > NB) ? NA : NB;
  localparam int IDX_WIDTH = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  state_t                 state, state_next;
  logic [IDX_WIDTH-1:0]   idx, idx_next;
  logic                   frame_err_next;
  logic                   a_wr, b_wr, op_wr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= LOAD_A;
      idx       <= '0;
      frame_err <= 1'b0;
      op        <= OP_ADD;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      frame_err <= frame_err_next;
      if (op_wr) begin
        op <= in_op;
      end
    end
  end

  // in_last must coincide exactly with the final B element; any other
  // placement discards the frame and restarts collection at A slot 0.
  always_comb begin
    state_next     = state;
    idx_next       = idx;
    frame_err_next = 1'b0;
    in_ready       = 1'b0;
    a_wr           = 1'b0;
    b_wr           = 1'b0;
    op_wr          = 1'b0;

    case (state)
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_wr  = 1'b1;
          op_wr = (idx == '0);
          if (in_last) begin
            frame_err_next = 1'b1;
            state_next     = LOAD_A;
            idx_next       = '0;
          end else if (idx == IDX_WIDTH'(NA - 1)) begin
            state_next = LOAD_B;
            idx_next   = '0;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end

      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          b_wr = 1'b1;
          if (idx == IDX_WIDTH'(NB - 1)) begin
            idx_next = '0;
            if (in_last) begin
              state_next = HOLD;
            end else begin
              frame_err_next = 1'b1;
              state_next     = LOAD_A;
            end
          end else if (in_last) begin
            frame_err_next = 1'b1;
            state_next     = LOAD_A;
            idx_next       = '0;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end

      HOLD: begin
        if (out_ready) begin
          state_next = LOAD_A;
          idx_next   = '0;
        end
      end

      default: begin
        state_next = LOAD_A;
        idx_next   = '0;
      end
    endcase
  end

  assign out_valid = (state == HOLD);

  matrix_pack_reg #(
    .word_size (word_size),
    .depth     (NA),
    .idx_width (IDX_WIDTH)
  ) u_pack_a (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (a_wr),
    .wr_idx  (idx),
    .wr_data (in_data),
    .data    (A)
  );

  matrix_pack_reg #(
    .word_size (word_size),
    .depth     (NB),
    .idx_width (IDX_WIDTH)
  ) u_pack_b (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (b_wr),
    .wr_idx  (idx),
    .wr_data (in_data),
    .data    (B)
  );

endmodule
